// File: rtl/cm_pkg_sys.sv
// -----------------------------------------------------------------------------
// cm_pkg_sys
// Shared system-record definitions used by the reset sequencer:
//   t_rst_seq_state  - reset sequencer FSM states (3-bit encoding)
//   RST_SEQ_STATE_W  - width of the encoded state
//   f_cnt_w()        - width of a counter that has to hold the value max_val
// -----------------------------------------------------------------------------
package cm_pkg_sys;

  localparam int RST_SEQ_STATE_W = 3;

  typedef enum logic [RST_SEQ_STATE_W-1:0] {
    ST_SYNC  = 3'd0,  // waiting for the synchronised raw reset release
    ST_HOLD  = 3'd1,  // stretching reset after release
    ST_REL   = 3'd2,  // releasing outputs one by one
    ST_RUN   = 3'd3,  // all outputs released
    ST_SWRST = 3'd4   // software reset hold
  } t_rst_seq_state;

  // Width needed to count from 0 up to and including max_val.
  function automatic int f_cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cm_rst_sync.sv
// -----------------------------------------------------------------------------
// cm_rst_sync
// Reset synchroniser: asynchronous assert, synchronous deassert. Reusable once
// per clock domain.
//   clk          in  destination clock
//   rst_n        in  raw asynchronous active-low reset
//   o_rst_sync_n out synchronised reset, rises STAGES edges after rst_n rises
// -----------------------------------------------------------------------------
module cm_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_rst_sync_n
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // values from before the edge; with = the chain would collapse to one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/cm_rst_seq.sv
// -----------------------------------------------------------------------------
// cm_rst_seq
// System reset sequencer. Synchronises the raw reset, stretches it for
// HOLD_CYCLES, then releases N_OUT reset domains in ascending order spaced by
// STAGE_GAP cycles. A 4-phase software request replays the hold/release
// sequence without touching the raw reset.
//   clk           in  system clock, rising edge
//   rst_n         in  raw reset, asynchronous, active-low
//   i_sw_req      in  software reset request (level, 4-phase)
//   o_sw_ack      out software reset completed
//   o_rst         out sequenced resets, bit k active at OUT_ACTIVE[k]
//   o_rst_sync_n  out synchronised copy of rst_n
//   o_ready       out all outputs released, FSM in RUN
//   o_state       out current FSM state (debug)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module cm_rst_seq
  import cm_pkg_sys::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter int               HOLD_CYCLES = 16,
  parameter int               STAGE_GAP   = 4,
  parameter int               N_OUT       = 3,
  parameter logic [N_OUT-1:0] OUT_ACTIVE  = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_sw_req,
  output logic                       o_sw_ack,
  output logic [N_OUT-1:0]           o_rst,
  output logic                       o_rst_sync_n,
  output logic                       o_ready,
  output logic [RST_SEQ_STATE_W-1:0] o_state
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = f_cnt_w(CNT_MAX);
  localparam int IDX_W   = $clog2(N_OUT + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic rst_sync_n;

  cm_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_rst_sync_n (rst_sync_n)
  );

  t_rst_seq_state   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] rst_q, rst_d;
  logic             ready_q, ready_d;
  logic             ack_q, ack_d;
  logic             sw_pend_q, sw_pend_d;  // current sequence was started by SWRST

  logic start_rel;  // release o_rst[0] on this edge
  logic enter_run;  // last output releases on this edge

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_d     = rst_q;
    ready_d   = ready_q;
    ack_d     = ack_q;
    sw_pend_d = sw_pend_q;
    start_rel = 1'b0;
    enter_run = 1'b0;

    unique case (state_q)
      ST_SYNC: begin
        // The cycle in which the synchronised release is observed already
        // counts as the first hold cycle; the synchroniser itself is not
        // shortened to gain that cycle.
        if (rst_sync_n) begin
          if (HOLD_CYCLES == 1) begin
            start_rel = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      ST_HOLD, ST_SWRST: begin
        if (cnt_q == HOLD_LAST) begin
          start_rel = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_REL: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          for (int k = 0; k < N_OUT; k++) begin
            if (k == int'(idx_q) + 1) rst_d[k] = ~OUT_ACTIVE[k];
          end
          if (int'(idx_q) + 1 == N_OUT - 1) enter_run = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (i_sw_req && !ack_q) begin
          state_d   = ST_SWRST;
          cnt_d     = '0;
          idx_d     = '0;
          rst_d     = OUT_ACTIVE;
          ready_d   = 1'b0;
          sw_pend_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase

    if (start_rel) begin
      rst_d[0] = ~OUT_ACTIVE[0];
      idx_d    = '0;
      cnt_d    = '0;
      if (N_OUT == 1) begin
        enter_run = 1'b1;
      end else begin
        state_d = ST_REL;
      end
    end

    // Acknowledge drops once the requester lets go; setting on RUN entry takes
    // priority so the acknowledge is visible for at least one cycle even when
    // the request was withdrawn mid-sequence.
    if (!i_sw_req) ack_d = 1'b0;

    if (enter_run) begin
      state_d = ST_RUN;
      ready_d = 1'b1;
      if (sw_pend_q) begin
        ack_d     = 1'b1;
        sw_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SYNC;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_q     <= OUT_ACTIVE;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      sw_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_q     <= rst_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      sw_pend_q <= sw_pend_d;
    end
  end

  assign o_rst        = rst_q;
  assign o_rst_sync_n = rst_sync_n;
  assign o_ready      = ready_q;
  assign o_sw_ack     = ack_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_cm_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_cm_rst_seq
// Directed bench for cm_rst_seq. Three instances share clock and raw reset:
//   u_dut  - default parameters (active-low outputs)
//   u_inv  - OUT_ACTIVE = 3'b101
//   u_min  - SYNC_STAGES=3, HOLD_CYCLES=1, STAGE_GAP=1, N_OUT=1
// Edges are counted from the raw reset release; outputs are sampled 1 time
// unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_cm_rst_seq;
  import cm_pkg_sys::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sw_req_a, sw_req_b, sw_req_c;

  logic       ack_a, ack_b, ack_c;
  logic [2:0] rst_a, rst_b;
  logic [0:0] rst_c;
  logic       sync_a, sync_b, sync_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic [2:0] st_a, st_b, st_c;

  cm_rst_seq u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sw_req     (sw_req_a),
    .o_sw_ack     (ack_a),
    .o_rst        (rst_a),
    .o_rst_sync_n (sync_a),
    .o_ready      (rdy_a),
    .o_state      (st_a)
  );

  cm_rst_seq #(
    .OUT_ACTIVE (3'b101)
  ) u_inv (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sw_req     (sw_req_b),
    .o_sw_ack     (ack_b),
    .o_rst        (rst_b),
    .o_rst_sync_n (sync_b),
    .o_ready      (rdy_b),
    .o_state      (st_b)
  );

  cm_rst_seq #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (1),
    .N_OUT       (1)
  ) u_min (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sw_req     (sw_req_c),
    .o_sw_ack     (ack_c),
    .o_rst        (rst_c),
    .o_rst_sync_n (sync_c),
    .o_ready      (rdy_c),
    .o_state      (st_c)
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) step();
  endtask

  // Call 1 time unit after a rising edge; the next edge is edge 1.
  task automatic release_rst();
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic apply_rst(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    release_rst();
  endtask

  initial begin
    rst_n    = 1'b0;
    sw_req_a = 1'b0;
    sw_req_b = 1'b0;
    sw_req_c = 1'b0;

    // ---------------- power-on, reset held 5 cycles ----------------
    repeat (5) @(posedge clk);
    #1;
    check("por_rst",      8'(rst_a),  8'h0);
    check("por_sync",     8'(sync_a), 8'h0);
    check("por_ready",    8'(rdy_a),  8'h0);
    check("por_ack",      8'(ack_a),  8'h0);
    check("por_state",    8'(st_a),   8'(ST_SYNC));
    check("por_inv_rst",  8'(rst_b),  8'h5);
    check("por_min_rst",  8'(rst_c),  8'h0);
    release_rst();

    step_to(1);
    check("e1_sync",      8'(sync_a), 8'h0);
    step_to(2);
    check("e2_sync",      8'(sync_a), 8'h1);
    check("e2_min_sync",  8'(sync_c), 8'h0);
    step_to(3);
    check("e3_state",     8'(st_a),   8'(ST_HOLD));
    check("e3_min_sync",  8'(sync_c), 8'h1);
    check("e3_min_rst",   8'(rst_c),  8'h0);
    check("e3_min_ready", 8'(rdy_c),  8'h0);
    step_to(4);
    check("e4_min_rst",   8'(rst_c),  8'h1);
    check("e4_min_ready", 8'(rdy_c),  8'h1);
    check("e4_min_state", 8'(st_c),   8'(ST_RUN));
    step_to(17);
    check("e17_rst",      8'(rst_a),  8'h0);
    check("e17_inv_rst",  8'(rst_b),  8'h5);
    step_to(18);
    check("e18_rst",      8'(rst_a),  8'h1);
    check("e18_state",    8'(st_a),   8'(ST_REL));
    check("e18_inv_rst",  8'(rst_b),  8'h4);
    step_to(21);
    check("e21_rst",      8'(rst_a),  8'h1);
    step_to(22);
    check("e22_rst",      8'(rst_a),  8'h3);
    check("e22_inv_rst",  8'(rst_b),  8'h6);
    step_to(25);
    check("e25_rst",      8'(rst_a),  8'h3);
    check("e25_ready",    8'(rdy_a),  8'h0);
    step_to(26);
    check("e26_rst",      8'(rst_a),  8'h7);
    check("e26_ready",    8'(rdy_a),  8'h1);
    check("e26_state",    8'(st_a),   8'(ST_RUN));
    check("e26_inv_rst",  8'(rst_b),  8'h2);
    check("e26_inv_ready",8'(rdy_b),  8'h1);

    // ---------------- software reset from RUN ----------------
    step_to(28);
    check("run_idle_ack", 8'(ack_a),  8'h0);
    sw_req_a = 1'b1;
    edge_n = 0;                       // entry edge is edge 1 of this phase
    step_to(1);
    check("sw_entry_rst",   8'(rst_a), 8'h0);
    check("sw_entry_ready", 8'(rdy_a), 8'h0);
    check("sw_entry_state", 8'(st_a),  8'(ST_SWRST));
    check("sw_inv_untouch", 8'(rst_b), 8'h2);
    step_to(16);
    check("sw_p15_rst",     8'(rst_a), 8'h0);
    step_to(17);
    check("sw_p16_rst",     8'(rst_a), 8'h1);
    step_to(21);
    check("sw_p20_rst",     8'(rst_a), 8'h3);
    step_to(24);
    check("sw_p23_ready",   8'(rdy_a), 8'h0);
    check("sw_p23_ack",     8'(ack_a), 8'h0);
    step_to(25);
    check("sw_p24_rst",     8'(rst_a), 8'h7);
    check("sw_p24_ready",   8'(rdy_a), 8'h1);
    check("sw_p24_ack",     8'(ack_a), 8'h1);
    step_to(28);
    check("sw_hold_ack",    8'(ack_a), 8'h1);
    check("sw_hold_state",  8'(st_a),  8'(ST_RUN));
    sw_req_a = 1'b0;
    step();
    check("sw_drop_ack",    8'(ack_a), 8'h0);
    check("sw_drop_state",  8'(st_a),  8'(ST_RUN));
    step_to(40);
    check("sw_no_repeat",   8'(st_a),  8'(ST_RUN));
    check("sw_no_rep_rst",  8'(rst_a), 8'h7);

    // ---------------- request held from reset release ----------------
    sw_req_a = 1'b1;
    apply_rst(3);
    step_to(25);
    check("held_e25_ready", 8'(rdy_a), 8'h0);
    step_to(26);
    check("held_e26_ready", 8'(rdy_a), 8'h1);
    check("held_e26_ack",   8'(ack_a), 8'h0);
    step_to(27);
    check("held_e27_state", 8'(st_a),  8'(ST_SWRST));
    check("held_e27_ready", 8'(rdy_a), 8'h0);
    check("held_e27_rst",   8'(rst_a), 8'h0);
    step_to(50);
    check("held_e50_ready", 8'(rdy_a), 8'h0);
    step_to(51);
    check("held_e51_ready", 8'(rdy_a), 8'h1);
    check("held_e51_ack",   8'(ack_a), 8'h1);
    step_to(60);
    check("held_e60_state", 8'(st_a),  8'(ST_RUN));
    check("held_e60_ack",   8'(ack_a), 8'h1);
    sw_req_a = 1'b0;
    step();
    check("held_drop_ack",  8'(ack_a), 8'h0);

    // ---------------- raw reset glitch mid-REL ----------------
    apply_rst(2);
    step_to(20);
    check("gl_e20_rst",     8'(rst_a), 8'h1);
    check("gl_e20_state",   8'(st_a),  8'(ST_REL));
    rst_n = 1'b0;
    #2;
    check("gl_async_rst",   8'(rst_a),  8'h0);
    check("gl_async_sync",  8'(sync_a), 8'h0);
    check("gl_async_ready", 8'(rdy_a),  8'h0);
    check("gl_async_state", 8'(st_a),   8'(ST_SYNC));
    check("gl_async_inv",   8'(rst_b),  8'h5);
    @(posedge clk);
    #1;
    release_rst();
    step_to(17);
    check("gl_e17_rst",     8'(rst_a), 8'h0);
    step_to(18);
    check("gl_e18_rst",     8'(rst_a), 8'h1);
    step_to(25);
    check("gl_e25_ready",   8'(rdy_a), 8'h0);
    step_to(26);
    check("gl_e26_ready",   8'(rdy_a), 8'h1);
    check("gl_e26_rst",     8'(rst_a), 8'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
